// File: rtl/lcd_text_refresh.sv
// LCD text refresh engine: shadow character buffer with per-line dirty flags,
// streamed to an HD44780-style transaction layer as address-set + data writes.
module lcd_text_refresh #(
  parameter int LINE_LEN  = 16,
  parameter int NUM_LINES = 2,
  parameter int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1,
  parameter int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 buf_we,
  input  logic [LW-1:0]        buf_line,
  input  logic [CW-1:0]        buf_col,
  input  logic [7:0]           buf_char,
  input  logic                 refresh_req,
  input  logic                 dirty_only,
  input  logic                 lcd_ready,
  output logic                 do_set_dd_ram_addr,
  output logic [6:0]           dd_ram_addr,
  input  logic                 set_dd_ram_addr_done,
  output logic                 do_write_data,
  output logic [7:0]           data_to_write,
  input  logic                 send_data_done,
  output logic                 busy,
  output logic                 refresh_done,
  output logic [NUM_LINES-1:0] dirty
);

  localparam int NCH = NUM_LINES * LINE_LEN;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    WRITE_CHAR,
    NEXT_LINE,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        line_q, line_d;
  logic [CW-1:0]        col_q, col_d;
  logic [NUM_LINES-1:0] sel_q, sel_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic                 pend_q, pend_d;
  logic [7:0]           buf_q [NCH];

  logic                 we_ok;
  logic [IW-1:0]        we_idx;
  logic [IW-1:0]        rd_idx;
  logic                 start;
  logic                 clr;
  logic [NUM_LINES-1:0] start_mask;
  logic                 first_ok, nxt_ok;
  logic [LW-1:0]        first_ln, nxt_ln;

  function automatic logic [6:0] base_addr(input logic [LW-1:0] l);
    logic [6:0] a;
    case (int'(l))
      0:       a = 7'h00;
      1:       a = 7'h40;
      2:       a = 7'h14;
      default: a = 7'h54;
    endcase
    return a;
  endfunction

  // Write qualification and flat buffer indices
  always_comb begin
    we_ok  = buf_we && (int'(buf_line) < NUM_LINES)
                    && (int'(buf_col) < LINE_LEN);
    we_idx = IW'(int'(buf_line) * LINE_LEN + int'(buf_col));
    rd_idx = IW'(int'(line_q) * LINE_LEN + int'(col_q));
  end

  assign start      = (state_q == IDLE) && lcd_ready
                      && (pend_q || refresh_req);
  assign start_mask = dirty_only ? dirty_q : '1;

  // Lowest selected line at start, and next selected line above line_q
  always_comb begin
    first_ok = 1'b0;
    first_ln = '0;
    nxt_ok   = 1'b0;
    nxt_ln   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (start_mask[i]) begin
        first_ok = 1'b1;
        first_ln = LW'(i);
      end
      if (sel_q[i] && (i > int'(line_q))) begin
        nxt_ok = 1'b1;
        nxt_ln = LW'(i);
      end
    end
  end

  // Refresh sequencer next-state
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    col_d   = col_q;
    sel_d   = sel_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d = start_mask;
          if (first_ok) begin
            line_d  = first_ln;
            clr     = 1'b1;
            state_d = SET_ADDR;
          end else begin
            state_d = DONE;
          end
        end
      end
      SET_ADDR: begin
        if (set_dd_ram_addr_done) begin
          col_d   = '0;
          state_d = WRITE_CHAR;
        end
      end
      WRITE_CHAR: begin
        if (send_data_done) begin
          if (int'(col_q) == LINE_LEN - 1) begin
            state_d = NEXT_LINE;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      NEXT_LINE: begin
        if (nxt_ok) begin
          line_d  = nxt_ln;
          clr     = 1'b1;
          state_d = SET_ADDR;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dirty flags: a new write wins over the clear on SET_ADDR entry
  always_comb begin
    dirty_d = dirty_q;
    if (clr) begin
      dirty_d[line_d] = 1'b0;
    end
    if (we_ok) begin
      dirty_d[buf_line] = 1'b1;
    end
  end

  // Requests merge into one pending flag until a refresh starts
  always_comb begin
    pend_d = pend_q;
    if (refresh_req) begin
      pend_d = 1'b1;
    end
    if (start) begin
      pend_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      col_q   <= '0;
      sel_q   <= '0;
      dirty_q <= '1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      col_q   <= col_d;
      sel_q   <= sel_d;
      dirty_q <= dirty_d;
      pend_q  <= pend_d;
    end
  end

  // Shadow character buffer, cleared to spaces
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        buf_q[i] <= 8'h20;
      end
    end else if (we_ok) begin
      buf_q[we_idx] <= buf_char;
    end
  end

  assign do_set_dd_ram_addr = (state_q == SET_ADDR);
  assign do_write_data      = (state_q == WRITE_CHAR);
  assign dd_ram_addr   = do_set_dd_ram_addr ? base_addr(line_q) : 7'h00;
  assign data_to_write = do_write_data ? buf_q[rd_idx] : 8'h00;
  assign busy          = (state_q != IDLE);
  assign refresh_done  = (state_q == DONE);
  assign dirty         = dirty_q;

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Bench for lcd_text_refresh: table of write+refresh vectors against a
// shadow-buffer model, plus directed reset / ready / merge sequences.
module tb_lcd_text_refresh;

  logic       clk = 1'b0;
  logic       reset;
  logic       buf_we;
  logic [0:0] buf_line;
  logic [3:0] buf_col;
  logic [7:0] buf_char;
  logic       refresh_req;
  logic       dirty_only;
  logic       lcd_ready;
  logic       do_set_dd_ram_addr;
  logic [6:0] dd_ram_addr;
  logic       set_dd_ram_addr_done;
  logic       do_write_data;
  logic [7:0] data_to_write;
  logic       send_data_done;
  logic       busy;
  logic       refresh_done;
  logic [1:0] dirty;

  int   tests = 0;
  int   fails = 0;
  logic overlap = 1'b0;
  logic [7:0] mbuf [2][16];

  typedef struct {
    bit         we;
    int         ln;
    int         col;
    logic [7:0] ch;
    bit         donly;
    logic [1:0] dbefore;
    logic [1:0] mask;
    logic [1:0] dafter;
  } vec_t;

  vec_t vt [6];

  lcd_text_refresh dut (
    .clk                  (clk),
    .reset                (reset),
    .buf_we               (buf_we),
    .buf_line             (buf_line),
    .buf_col              (buf_col),
    .buf_char             (buf_char),
    .refresh_req          (refresh_req),
    .dirty_only           (dirty_only),
    .lcd_ready            (lcd_ready),
    .do_set_dd_ram_addr   (do_set_dd_ram_addr),
    .dd_ram_addr          (dd_ram_addr),
    .set_dd_ram_addr_done (set_dd_ram_addr_done),
    .do_write_data        (do_write_data),
    .data_to_write        (data_to_write),
    .send_data_done       (send_data_done),
    .busy                 (busy),
    .refresh_done         (refresh_done),
    .dirty                (dirty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (do_set_dd_ram_addr && do_write_data) overlap = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if ((which == 0 && do_set_dd_ram_addr) ||
          (which == 1 && do_write_data) ||
          (which == 2 && refresh_done)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL timeout_%0d: got no event, want event in 200 cycles",
               which);
    end
  endtask

  task automatic wr_buf(input int ln, input int col, input logic [7:0] ch);
    buf_we   = 1'b1;
    buf_line = 1'(ln);
    buf_col  = 4'(col);
    buf_char = ch;
    @(negedge clk);
    buf_we = 1'b0;
    mbuf[ln][col] = ch;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic ack(input bit which);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (which) send_data_done = 1'b1;
    else       set_dd_ram_addr_done = 1'b1;
    @(negedge clk);
    send_data_done       = 1'b0;
    set_dd_ram_addr_done = 1'b0;
  endtask

  // Plays the downstream layer for one refresh; optional injection while
  // the given line/column is being written (1 = buffer write, 2 = 2 reqs).
  task automatic serve(input logic [1:0] mask, input int il, input int ic,
                       input int kind, input logic [1:0] dexp,
                       input string nm);
    bit ok;
    for (int l = 0; l < 2; l++) begin
      if (mask[l]) begin
        wait_for(0, ok);
        if (!ok) return;
        chk($sformatf("%s_addr%0d", nm, l), 32'(dd_ram_addr),
            (l == 0) ? 32'h00 : 32'h40);
        ack(1'b0);
        for (int c = 0; c < 16; c++) begin
          wait_for(1, ok);
          if (!ok) return;
          chk($sformatf("%s_L%0dC%0d", nm, l, c), 32'(data_to_write),
              32'(mbuf[l][c]));
          if (kind == 1 && l == il && c == ic) wr_buf(0, 5, 8'h71);
          if (kind == 2 && l == il && c == ic) begin
            refresh_req = 1'b1;
            @(negedge clk);
            refresh_req = 1'b0;
            @(negedge clk);
            refresh_req = 1'b1;
            @(negedge clk);
            refresh_req = 1'b0;
          end
          ack(1'b1);
        end
      end
    end
    wait_for(2, ok);
    if (!ok) return;
    chk({nm, "_dirty"}, 32'(dirty), 32'(dexp));
  endtask

  initial begin
    bit   ok;
    bit   quiet;
    int   lat;

    reset = 1'b0;
    buf_we = 1'b0;
    buf_line = '0;
    buf_col = '0;
    buf_char = '0;
    refresh_req = 1'b0;
    dirty_only = 1'b0;
    lcd_ready = 1'b1;
    set_dd_ram_addr_done = 1'b0;
    send_data_done = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 16; c++) mbuf[l][c] = 8'h20;

    vt[0] = '{we:0, ln:0, col:0,  ch:8'h00, donly:0,
              dbefore:2'b11, mask:2'b11, dafter:2'b00};
    vt[1] = '{we:1, ln:1, col:3,  ch:8'h41, donly:1,
              dbefore:2'b10, mask:2'b10, dafter:2'b00};
    vt[2] = '{we:1, ln:0, col:0,  ch:8'h5A, donly:1,
              dbefore:2'b01, mask:2'b01, dafter:2'b00};
    vt[3] = '{we:0, ln:0, col:0,  ch:8'h00, donly:1,
              dbefore:2'b00, mask:2'b00, dafter:2'b00};
    vt[4] = '{we:1, ln:0, col:15, ch:8'h7E, donly:0,
              dbefore:2'b01, mask:2'b11, dafter:2'b00};
    vt[5] = '{we:1, ln:1, col:15, ch:8'h30, donly:1,
              dbefore:2'b10, mask:2'b10, dafter:2'b00};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(refresh_done), 32'h0);
    chk("rst_set", 32'(do_set_dd_ram_addr), 32'h0);
    chk("rst_wr", 32'(do_write_data), 32'h0);
    chk("rst_addr", 32'(dd_ram_addr), 32'h0);
    chk("rst_data", 32'(data_to_write), 32'h0);
    chk("rst_dirty", 32'(dirty), 32'h3);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].we) wr_buf(vt[i].ln, vt[i].col, vt[i].ch);
      chk($sformatf("row%0d_dpre", i), 32'(dirty), 32'(vt[i].dbefore));
      dirty_only = vt[i].donly;
      pulse_req();
      serve(vt[i].mask, -1, -1, 0, vt[i].dafter, $sformatf("row%0d", i));
    end

    // Request while the transaction layer is not ready
    lcd_ready = 1'b0;
    dirty_only = 1'b0;
    pulse_req();
    quiet = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy || do_set_dd_ram_addr || do_write_data) quiet = 1'b1;
    end
    chk("notready_quiet", 32'(quiet), 32'h0);
    lcd_ready = 1'b1;
    lat = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (do_set_dd_ram_addr) begin
        lat = n;
        break;
      end
    end
    chk("ready_latency", 32'(lat), 32'h1);
    if (lat != 0) serve(2'b11, -1, -1, 0, 2'b00, "ready");

    // Write to an already-sent column of the line being refreshed
    pulse_req();
    serve(2'b11, 0, 10, 1, 2'b01, "mid_we");

    // Two requests during a refresh merge into one follow-up refresh
    pulse_req();
    serve(2'b11, 0, 3, 2, 2'b00, "dbl_req");
    serve(2'b11, -1, -1, 0, 2'b00, "follow");
    quiet = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) quiet = 1'b1;
    end
    chk("no_third", 32'(quiet), 32'h0);

    // Asynchronous reset during a character write
    pulse_req();
    wait_for(0, ok);
    ack(1'b0);
    wait_for(1, ok);
    chk("pre_rst_wr", 32'(do_write_data), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_wr", 32'(do_write_data), 32'h0);
    chk("arst_set", 32'(do_set_dd_ram_addr), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_data", 32'(data_to_write), 32'h0);
    chk("arst_dirty", 32'(dirty), 32'h3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy || do_set_dd_ram_addr || do_write_data) quiet = 1'b1;
    end
    chk("post_rst_idle", 32'(quiet), 32'h0);
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 16; c++) mbuf[l][c] = 8'h20;
    dirty_only = 1'b1;
    pulse_req();
    serve(2'b11, -1, -1, 0, 2'b00, "post_rst");

    chk("no_overlap", 32'(overlap), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_text_refresh.md
LCD_TEXT_REFRESH -- requirements
Module: lcd_text_refresh

Interface
REQ-001 The block SHALL have parameter LINE_LEN, default 16, giving characters per display line (1..20).
REQ-002 The block SHALL have parameter NUM_LINES, default 2, giving display lines (1..4); line base DD RAM addresses fixed at 0x00, 0x40, 0x14, 0x54.
REQ-003 The block SHALL have parameter CW = clog2(LINE_LEN) and LW = max(1, clog2(NUM_LINES)) as derived widths.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 buf_we  in  1  write one character into the shadow buffer this cycle.
REQ-007 buf_line  in  LW  line index for buf_we.
REQ-008 buf_col  in  CW  column index for buf_we.
REQ-009 buf_char  in  8  character code for buf_we.
REQ-010 refresh_req  in  1  single-cycle pulse requesting a display refresh.
REQ-011 dirty_only  in  1  sampled at refresh start: 1 = rewrite only dirty lines, 0 = rewrite all lines.
REQ-012 lcd_ready  in  1  high once the downstream transaction layer has finished its init sequence.
REQ-013 do_set_dd_ram_addr  out  1  level request to downstream: set DD RAM address.
REQ-014 dd_ram_addr  out  7  address for do_set_dd_ram_addr.
REQ-015 set_dd_ram_addr_done  in  1  one-cycle completion pulse for an address set.
REQ-016 do_write_data  out  1  level request to downstream: write one character.
REQ-017 data_to_write  out  8  character for do_write_data.
REQ-018 send_data_done  in  1  one-cycle completion pulse for a character write.
REQ-019 busy  out  1  high from refresh start until refresh_done.
REQ-020 refresh_done  out  1  one-cycle pulse when a refresh completes.
REQ-021 dirty  out  NUM_LINES  per-line dirty flags.

Function
REQ-022 Shadow buffer SHALL be NUM_LINES x LINE_LEN x 8 bits; buf_we writes take effect on the next edge, in any state.
REQ-023 buf_we with buf_line >= NUM_LINES or buf_col >= LINE_LEN SHALL be ignored (no buffer or dirty change).
REQ-024 A valid buf_we SHALL set dirty[buf_line]; a set and a clear in the same cycle on the same line SHALL leave the flag set.
REQ-025 FSM states SHALL be IDLE, SET_ADDR, WRITE_CHAR, NEXT_LINE, DONE.
REQ-026 IDLE -> SET_ADDR when a refresh is pending and lcd_ready=1; line pointer starts at the first selected line (all lines if dirty_only=0, else lowest dirty line); if no line selected -> DONE directly.
REQ-027 On entering SET_ADDR the block SHALL clear dirty[line] and hold do_set_dd_ram_addr=1 with dd_ram_addr = base(line) until set_dd_ram_addr_done, then go to WRITE_CHAR with column 0.
REQ-028 In WRITE_CHAR the block SHALL hold do_write_data=1 with data_to_write = buffer[line][col], read live each cycle, until send_data_done; then col+1, or NEXT_LINE after col = LINE_LEN-1.
REQ-029 NEXT_LINE SHALL advance to the next selected line -> SET_ADDR, or -> DONE when none remain; it takes exactly one cycle.
REQ-030 DONE SHALL pulse refresh_done for one cycle and return to IDLE; busy is high in SET_ADDR, WRITE_CHAR, NEXT_LINE and DONE.
REQ-031 do_set_dd_ram_addr and do_write_data SHALL never be high together; both low outside SET_ADDR/WRITE_CHAR.
REQ-032 refresh_req while busy or while lcd_ready=0 SHALL set a single pending flag (further requests merge); pending clears when a refresh starts.
REQ-033 Done pulses arriving in a state not expecting them SHALL be ignored.
REQ-034 A character written to a line already past SET_ADDR in the current refresh SHALL leave that line dirty for the next refresh.

Reset
REQ-035 While reset=0: state IDLE, pending 0, dirty all 1, buffer all 0x20 (space), all request outputs 0, dd_ram_addr 0, data_to_write 0, busy 0, refresh_done 0.
REQ-036 Reset asserted mid-refresh SHALL abort immediately; after release the block waits for a new refresh_req.

Verification
REQ-037 Defaults, lcd_ready=1, after reset refresh_req -> addr 0x00 + 16 writes of 0x20, addr 0x40 + 16 writes, one refresh_done, dirty=2'b00.
REQ-038 Write 'A' at line 1 col 3, dirty_only=1, refresh -> only addr 0x40 set, 16 writes, 4th is 0x41; line 0 untouched.
REQ-039 refresh_req with lcd_ready=0 for 50 cycles then lcd_ready=1 -> no requests during wait, refresh starts within 2 cycles after.
REQ-040 Two refresh_req pulses during a refresh -> exactly one further refresh follows.
REQ-041 buf_we to line 0 col 5 while WRITE_CHAR on line 0 col 10 -> dirty[0]=1 after refresh_done.
REQ-042 reset=0 during WRITE_CHAR -> requests drop asynchronously; buffer back to 0x20, dirty all 1.
